end_of_sim_ctrl: RTL and testbench



---
 rtl/end_of_sim_ctrl.sv | 149 ++++++++++++++
 tb/tb_end_of_sim_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/end_of_sim_ctrl.sv
// Purpose: decides when and why simulation ends (error/done/watchdog), drains, then raises a sticky end request.
// Latency: cause registered at the deciding edge; EndOfSim_SO follows DRAIN_CYCLES+1 edges later (same edge if 0).
// Backpressure: none; once END is reached every output holds until reset.
module end_of_sim_ctrl #(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned IDLE_CYCLES    = 4096,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic [NUM_SOURCES-1:0] Done_SI,
  input  logic [NUM_SOURCES-1:0] Error_SI,
  input  logic                   Activity_SI,
  output logic                   EndOfSim_SO,
  output logic                   Pass_SO,
  output logic                   Fail_SO,
  output logic [1:0]             Cause_DO,
  output logic [CNT_WIDTH-1:0]   CycleCnt_DO
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_DONE  = 2'd1;
  localparam logic [1:0] C_ERROR = 2'd2;
  localparam logic [1:0] C_WDOG  = 2'd3;

  // Comparisons are done in 64 bits so the counter width never truncates the limits.
  localparam logic [63:0] TIMEOUT_V  = 64'(TIMEOUT_CYCLES);
  localparam logic [63:0] IDLE_V     = 64'(IDLE_CYCLES);
  // Only consulted while in DRAIN, which is unreachable when DRAIN_CYCLES is 0.
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES) - 32'd1;

  logic [1:0]             state, state_nxt;
  logic [NUM_SOURCES-1:0] done_sticky, sticky_nxt;
  logic [31:0]            idle_cnt, idle_nxt;
  logic [31:0]            drain_cnt, drain_nxt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic [1:0]             cause_nxt;
  logic                   eos_nxt, pass_nxt, fail_nxt;

  logic       any_err, all_done, timeout_hit, idle_hit;
  logic       exit_vld;
  logic [1:0] exit_cause;

  assign any_err     = |Error_SI;
  assign all_done    = &(done_sticky | Done_SI);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((64'(CycleCnt_DO) + 64'd1) == TIMEOUT_V);
  assign idle_hit    = (IDLE_CYCLES != 0) && !Activity_SI && ((64'(idle_cnt) + 64'd1) == IDLE_V);

  // Exit cause with fixed priority ERROR > DONE > WATCHDOG.
  always_comb begin
    exit_vld   = 1'b1;
    exit_cause = C_NONE;
    if (any_err) begin
      exit_cause = C_ERROR;
    end else if (all_done) begin
      exit_cause = C_DONE;
    end else if (timeout_hit || idle_hit) begin
      exit_cause = C_WDOG;
    end else begin
      exit_vld = 1'b0;
    end
  end

  // Next-state and next-output computation for RUN / DRAIN / END.
  always_comb begin
    state_nxt  = state;
    sticky_nxt = done_sticky;
    idle_nxt   = idle_cnt;
    drain_nxt  = drain_cnt;
    cnt_nxt    = CycleCnt_DO;
    cause_nxt  = Cause_DO;
    eos_nxt    = EndOfSim_SO;
    case (state)
      ST_RUN: begin
        if (CycleCnt_DO != '1) begin
          cnt_nxt = CycleCnt_DO + CNT_WIDTH'(1);
        end
        sticky_nxt = done_sticky | Done_SI;
        if (Activity_SI) begin
          idle_nxt = '0;
        end else if (idle_cnt != '1) begin
          idle_nxt = idle_cnt + 32'd1;
        end
        if (exit_vld) begin
          cause_nxt = exit_cause;
          drain_nxt = '0;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = ST_END;
            eos_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_nxt = drain_cnt + 32'd1;
        // A late error turns a clean finish into a failure; watchdog stays as is.
        if (any_err && (Cause_DO == C_DONE)) begin
          cause_nxt = C_ERROR;
        end
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_END;
        end
      end
      ST_END: begin
        eos_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Verdict only ever shows together with the end request.
  assign pass_nxt = eos_nxt && (cause_nxt == C_DONE);
  assign fail_nxt = eos_nxt && ((cause_nxt == C_ERROR) || (cause_nxt == C_WDOG));

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state       <= ST_RUN;
      done_sticky <= '0;
      idle_cnt    <= '0;
      drain_cnt   <= '0;
      CycleCnt_DO <= '0;
      Cause_DO    <= C_NONE;
      EndOfSim_SO <= 1'b0;
      Pass_SO     <= 1'b0;
      Fail_SO     <= 1'b0;
    end else begin
      state       <= state_nxt;
      done_sticky <= sticky_nxt;
      idle_cnt    <= idle_nxt;
      drain_cnt   <= drain_nxt;
      CycleCnt_DO <= cnt_nxt;
      Cause_DO    <= cause_nxt;
      EndOfSim_SO <= eos_nxt;
      Pass_SO     <= pass_nxt;
      Fail_SO     <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_end_of_sim_ctrl.sv
// Purpose: scoreboard bench for end_of_sim_ctrl; two instances (with drain / without drain) share one stimulus.
// Latency: expected end edge, cause and verdict are predicted per run and matched when EndOfSim_SO rises.
// Backpressure: none; each run is a fixed-length window followed by a one-cycle reset.
module tb_end_of_sim_ctrl;

  localparam int LMAX    = 270;
  localparam int NRUNS   = 14;
  localparam int A_TO    = 250;
  localparam int A_IDLE  = 12;
  localparam int A_DRAIN = 4;
  localparam int B_TO    = 100;
  localparam int B_IDLE  = 0;
  localparam int B_DRAIN = 0;

  typedef struct {
    logic [1:0] cause0;
    logic [1:0] cause;
    logic       pass;
    logic       fail;
    int         k;
    int         end_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] done = '0;
  logic [3:0] err = '0;
  logic       act = 1'b0;

  logic        eos_a, pass_a, fail_a, eos_b, pass_b, fail_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] cnt_a, cnt_b;

  logic [3:0] done_v [0:LMAX];
  logic [3:0] err_v  [0:LMAX];
  logic       act_v  [0:LMAX];

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  int ectr   = 0;
  logic eos_a_q = 1'b0;
  logic eos_b_q = 1'b0;

  end_of_sim_ctrl #(.NUM_SOURCES(4), .TIMEOUT_CYCLES(A_TO), .IDLE_CYCLES(A_IDLE),
                    .DRAIN_CYCLES(A_DRAIN), .CNT_WIDTH(32)) dut_a (
    .Clk_CI(clk), .Rst_RI(rst), .Done_SI(done), .Error_SI(err), .Activity_SI(act),
    .EndOfSim_SO(eos_a), .Pass_SO(pass_a), .Fail_SO(fail_a), .Cause_DO(cause_a), .CycleCnt_DO(cnt_a));

  end_of_sim_ctrl #(.NUM_SOURCES(4), .TIMEOUT_CYCLES(B_TO), .IDLE_CYCLES(B_IDLE),
                    .DRAIN_CYCLES(B_DRAIN), .CNT_WIDTH(32)) dut_b (
    .Clk_CI(clk), .Rst_RI(rst), .Done_SI(done), .Error_SI(err), .Activity_SI(act),
    .EndOfSim_SO(eos_b), .Pass_SO(pass_b), .Fail_SO(fail_b), .Cause_DO(cause_b), .CycleCnt_DO(cnt_b));

  always #5 clk = ~clk;

  // Edge number since reset release: after edge e (sampled on negedge) ectr == e.
  always @(posedge clk) ectr <= rst ? 0 : ectr + 1;

  task automatic chk(input string name, input longint act_val, input longint exp_val);
    checks++;
    if (act_val != exp_val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act_val, exp_val, ectr);
    end
  endtask

  // Reference: scan the stimulus trace for the first edge meeting an exit rule, then apply the drain window.
  function automatic exp_t model(input int to, input int idle, input int d);
    exp_t r;
    logic [3:0] seen;
    int run;
    seen = '0; run = 0; r.cause0 = 2'd0; r.k = 0;
    for (int e = 1; e <= LMAX; e++) begin
      if (err_v[e] != 0) r.cause0 = 2'd2;
      else if ((seen | done_v[e]) == 4'hF) r.cause0 = 2'd1;
      else if (to != 0 && e == to) r.cause0 = 2'd3;
      else if (idle != 0 && !act_v[e] && run + 1 == idle) r.cause0 = 2'd3;
      if (r.cause0 != 0) begin
        r.k = e;
        break;
      end
      seen |= done_v[e];
      run = act_v[e] ? 0 : run + 1;
    end
    r.cause = r.cause0;
    if (r.cause == 2'd1)
      for (int e = r.k + 1; e <= r.k + d; e++)
        if (err_v[e] != 0) r.cause = 2'd2;
    r.pass = (r.cause == 2'd1);
    r.fail = (r.cause >= 2'd2);
    r.end_edge = (d == 0) ? r.k : r.k + d + 1;
    return r;
  endfunction

  task automatic fill(input int s);
    int pd, pe, pa;
    for (int e = 0; e <= LMAX; e++) begin
      done_v[e] = '0; err_v[e] = '0; act_v[e] = 1'b1;
    end
    case (s)
      0, 5: begin
        done_v[10] = 4'h1; done_v[20] = 4'h2; done_v[30] = 4'h4; done_v[40] = 4'h8;
      end
      1: begin
        done_v[50] = 4'hF; err_v[50] = 4'h4;
      end
      2: begin
        done_v[40] = 4'hF; err_v[42] = 4'h1;
      end
      3: ;
      4: begin
        for (int e = 21; e <= LMAX; e++) act_v[e] = 1'b0;
        act_v[25] = 1'b1;
      end
      default: begin
        case ($urandom_range(0, 2))
          0: pd = 3; 1: pd = 10; default: pd = 30;
        endcase
        case ($urandom_range(0, 2))
          0: pe = 0; 1: pe = 3; default: pe = 10;
        endcase
        case ($urandom_range(0, 2))
          0: pa = 300; 1: pa = 850; default: pa = 1000;
        endcase
        for (int e = 1; e <= LMAX; e++) begin
          for (int b = 0; b < 4; b++) done_v[e][b] = ($urandom_range(0, 999) < pd);
          if ($urandom_range(0, 999) < pe) err_v[e][$urandom_range(0, 3)] = 1'b1;
          act_v[e] = ($urandom_range(0, 999) < pa);
        end
      end
    endcase
    // Late errors land in END for both instances and must not disturb anything.
    for (int e = 260; e <= LMAX; e++)
      if ($urandom_range(0, 3) == 0) err_v[e] = 4'($urandom_range(1, 15));
  endtask

  // Monitor for instance A: compares a popped expectation when the end request rises.
  always @(negedge clk) begin
    exp_t x;
    if (eos_a && !eos_a_q) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_end: end request at edge %0d, none expected", ectr);
      end else begin
        x = qa.pop_front();
        chk("a_end_edge", ectr, x.end_edge);
        chk("a_cause", cause_a, x.cause);
        chk("a_pass", pass_a, x.pass);
        chk("a_fail", fail_a, x.fail);
        chk("a_cnt", cnt_a, x.k);
      end
    end
    chk("a_verdict_outside_end", (pass_a | fail_a) & ~eos_a, 0);
    chk("a_pass_and_fail", pass_a & fail_a, 0);
    eos_a_q = eos_a;
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t x;
    if (eos_b && !eos_b_q) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_end: end request at edge %0d, none expected", ectr);
      end else begin
        x = qb.pop_front();
        chk("b_end_edge", ectr, x.end_edge);
        chk("b_cause", cause_b, x.cause);
        chk("b_pass", pass_b, x.pass);
        chk("b_fail", fail_b, x.fail);
        chk("b_cnt", cnt_b, x.k);
      end
    end
    chk("b_verdict_outside_end", (pass_b | fail_b) & ~eos_b, 0);
    chk("b_pass_and_fail", pass_b & fail_b, 0);
    eos_b_q = eos_b;
  end

  // Driver: one reset cycle (from END on every run after the first), then a fixed window of stimulus.
  initial begin
    exp_t ea, eb;
    for (int r = 0; r < NRUNS; r++) begin
      fill(r);
      ea = model(A_TO, A_IDLE, A_DRAIN);
      eb = model(B_TO, B_IDLE, B_DRAIN);
      rst = 1'b1; done = '0; err = '0; act = 1'b0;
      @(negedge clk);
      chk("a_rst_eos", eos_a, 0);   chk("b_rst_eos", eos_b, 0);
      chk("a_rst_pass", pass_a, 0); chk("b_rst_pass", pass_b, 0);
      chk("a_rst_fail", fail_a, 0); chk("b_rst_fail", fail_b, 0);
      chk("a_rst_cause", cause_a, 0); chk("b_rst_cause", cause_b, 0);
      chk("a_rst_cnt", cnt_a, 0);   chk("b_rst_cnt", cnt_b, 0);
      qa.push_back(ea);
      qb.push_back(eb);
      rst = 1'b0;
      for (int e = 1; e <= LMAX; e++) begin
        done = done_v[e]; err = err_v[e]; act = act_v[e];
        @(negedge clk);
        if (e == 1) begin
          chk("a_first_cnt", cnt_a, 1);
          chk("b_first_cnt", cnt_b, 1);
        end
        if (e == ea.k) begin
          chk("a_exit_cause", cause_a, ea.cause0);
          chk("a_exit_cnt", cnt_a, ea.k);
        end
        if (e == eb.k) begin
          chk("b_exit_cause", cause_b, eb.cause0);
          chk("b_exit_cnt", cnt_b, eb.k);
        end
      end
      chk("a_end_missing", qa.size(), 0);
      chk("b_end_missing", qb.size(), 0);
      qa.delete();
      qb.delete();
      chk("a_hold_eos", eos_a, 1);        chk("b_hold_eos", eos_b, 1);
      chk("a_hold_cause", cause_a, ea.cause); chk("b_hold_cause", cause_b, eb.cause);
      chk("a_hold_pass", pass_a, ea.pass); chk("b_hold_pass", pass_b, eb.pass);
      chk("a_hold_fail", fail_a, ea.fail); chk("b_hold_fail", fail_b, eb.fail);
      chk("a_hold_cnt", cnt_a, ea.k);     chk("b_hold_cnt", cnt_b, eb.k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
